pipe_skid_reg: RTL

Parametrised elastic pipeline register, the successor to the fixed-width IF/ID stall register.
- Replaces the global stall with a valid/ready handshake on both sides.
- Adds an optional 2-entry skid buffer, so `in_ready` is a registered signal and no combinational ready path crosses stage boundaries.
- Adds flush with bubble insertion and a saturating back-pressure counter for performance debug.
- Instantiated between every pair of CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_skid_reg.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the CPU pipeline stage registers: skid state encoding,
// NOP encoding and the per-stage payload structs that size DATA_W.
package pipe_pkg;

    // Encoding equals the number of held beats, so the state drives occupancy directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        we;
    } memwb_t;

    localparam int IFID_W  = $bits(ifid_t);
    localparam int IDEX_W  = $bits(idex_t);
    localparam int EXMEM_W = $bits(exmem_t);
    localparam int MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// cleared only by rst.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign count = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer,
// flush with bubble insertion and a saturating back-pressure counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter int                SKID_EN    = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic              r_in_rdy;
    logic [DATA_W-1:0] r_main_p1;
    logic [DATA_W-1:0] r_skid_p1;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_emit;
    logic w_ld_main;
    logic w_ld_skid;
    logic w_pop_skid;

    assign w_out_valid = (r_state != EMPTY);
    // Skid mode uses the registered ready; flush always blocks a new beat.
    assign w_in_ready  = ((SKID_EN != 0) ? r_in_rdy : (~w_out_valid | out_ready)) & ~flush;
    assign w_accept    = in_valid & w_in_ready;
    assign w_emit      = w_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_in_rdy <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt != FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_main   = 1'b0;
        w_ld_skid   = 1'b0;
        w_pop_skid  = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_ld_main   = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_emit) begin
                    w_ld_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_emit) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_emit) begin
                    w_state_nxt = ONE;
                    w_pop_skid  = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
        end
    end

    // Stage p1: payload storage; bubbles come from the output mux, not the flops.
    always_ff @(posedge clk) begin
        if (w_ld_main) begin
            r_main_p1 <= in_data;
        end else if (w_pop_skid) begin
            r_main_p1 <= r_skid_p1;
        end
        if (w_ld_skid) begin
            r_skid_p1 <= in_data;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_main_p1 : BUBBLE_VAL;
    assign occupancy = r_state;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule
